// File: rtl/mmu_refill.sv
// Hardware page-table refill engine: on an MMU miss, fetch the PTE for the
// faulting {sup, ins, VPN} and write it back to the MMU, or raise pte_fault.
module mmu_refill #(
    parameter int RV   = 16,
    parameter int VA   = RV,
    parameter int NMMU = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    input  logic          fault_valid,
    input  logic [RV-1:0] fault_info,
    input  logic [RV-1:0] ptbase,
    output logic          mem_req,
    output logic [RV-1:0] mem_addr,
    input  logic          mem_ack,
    input  logic [RV-1:0] mem_rdata,
    output logic          reg_write,
    output logic [RV-1:0] reg_data,
    output logic          busy,
    output logic          done,
    output logic          pte_fault
);
    localparam int K = $clog2(NMMU);

    typedef enum logic [1:0] {IDLE, FETCH, WRITE, FAIL} state_t;
    state_t state_reg;

    logic [K+1:0]  idx;
    logic [RV-1:0] addr_next;

    // Each PTE is one halfword, so the index is scaled by two; overflow wraps.
    assign idx       = {fault_info[2], fault_info[3], fault_info[RV-1 -: K]};
    assign addr_next = ptbase + ({{(RV-K-2){1'b0}}, idx} << 1);

    // Fields of the fault register and PTE that the refill never looks at.
    logic          unused_bits;
    logic [VA-1:0] unused_va;
    assign unused_bits = ^{fault_info[RV-K-1:4], fault_info[0], mem_rdata[0]};
    assign unused_va   = '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            mem_req   <= 1'b0;
            mem_addr  <= '0;
            reg_write <= 1'b0;
            reg_data  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pte_fault <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (fault_valid && enable) begin
                        busy <= 1'b1;
                        if (fault_info[1]) begin
                            state_reg <= FETCH;
                            mem_req   <= 1'b1;
                            mem_addr  <= addr_next;
                        end else begin
                            state_reg <= FAIL;
                            pte_fault <= 1'b1;
                        end
                    end
                end
                FETCH: begin
                    if (mem_ack) begin
                        mem_req  <= 1'b0;
                        mem_addr <= '0;
                        if (mem_rdata[1]) begin
                            state_reg <= WRITE;
                            reg_write <= 1'b1;
                            done      <= 1'b1;
                            reg_data  <= {mem_rdata[RV-1:1], 1'b1};
                        end else begin
                            state_reg <= FAIL;
                            pte_fault <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    state_reg <= IDLE;
                    reg_write <= 1'b0;
                    done      <= 1'b0;
                    reg_data  <= '0;
                    busy      <= 1'b0;
                end
                FAIL: begin
                    state_reg <= IDLE;
                    pte_fault <= 1'b0;
                    busy      <= 1'b0;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mmu_refill.sv
// Directed plus randomized bench for mmu_refill against a transaction-level model.
module tb_mmu_refill;
    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        fault_valid;
    logic [15:0] fault_info;
    logic [15:0] ptbase;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic        reg_write;
    logic [15:0] reg_data;
    logic        busy;
    logic        done;
    logic        pte_fault;

    int checks = 0;
    int errors = 0;

    mmu_refill dut (
        .clk(clk), .reset(reset), .enable(enable), .fault_valid(fault_valid),
        .fault_info(fault_info), .ptbase(ptbase), .mem_req(mem_req),
        .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .reg_write(reg_write), .reg_data(reg_data), .busy(busy),
        .done(done), .pte_fault(pte_fault)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".busy"}, {15'd0, busy}, 16'd0);
        check({tag, ".mem_req"}, {15'd0, mem_req}, 16'd0);
        check({tag, ".mem_addr"}, mem_addr, 16'd0);
        check({tag, ".reg_write"}, {15'd0, reg_write}, 16'd0);
        check({tag, ".reg_data"}, reg_data, 16'd0);
        check({tag, ".done"}, {15'd0, done}, 16'd0);
        check({tag, ".pte_fault"}, {15'd0, pte_fault}, 16'd0);
    endtask

    // Reference: table index = sup*16 + ins*8 + VPN, entries are 2 bytes.
    function automatic logic [15:0] model_addr(input logic [15:0] base, input logic [15:0] finfo);
        int vpn, idx, sum;
        vpn = int'(finfo) / 8192;
        idx = int'(finfo[2]) * 16 + int'(finfo[3]) * 8 + vpn;
        sum = (int'(base) + idx * 2) % 65536;
        return 16'(sum);
    endfunction

    // One complete fault transaction, checked cycle by cycle.
    task automatic run_fault(input string tag, input logic [15:0] base, input logic [15:0] finfo,
                             input logic [15:0] pte, input int ack_delay, input bit collide,
                             input bit drop_enable);
        logic [15:0] exp_addr;
        exp_addr    = model_addr(base, finfo);
        enable      = 1'b1;
        fault_valid = 1'b1;
        fault_info  = finfo;
        ptbase      = base;
        step();
        fault_valid = 1'b0;
        fault_info  = 16'($urandom);
        ptbase      = 16'($urandom);
        if (drop_enable) enable = 1'b0;
        if (finfo[1] == 1'b0) begin
            check({tag, ".prot.pte_fault"}, {15'd0, pte_fault}, 16'd1);
            check({tag, ".prot.busy"}, {15'd0, busy}, 16'd1);
            check({tag, ".prot.mem_req"}, {15'd0, mem_req}, 16'd0);
            check({tag, ".prot.reg_write"}, {15'd0, reg_write}, 16'd0);
            step();
            check_idle({tag, ".prot.after"});
            return;
        end
        check({tag, ".mem_req"}, {15'd0, mem_req}, 16'd1);
        check({tag, ".mem_addr"}, mem_addr, exp_addr);
        check({tag, ".busy"}, {15'd0, busy}, 16'd1);
        for (int d = 0; d < ack_delay; d++) begin
            if (collide && d == 1) begin
                fault_valid = 1'b1;
                fault_info  = 16'hE00E;
                ptbase      = 16'h1234;
            end
            step();
            fault_valid = 1'b0;
            check({tag, ".hold.mem_req"}, {15'd0, mem_req}, 16'd1);
            check({tag, ".hold.mem_addr"}, mem_addr, exp_addr);
            check({tag, ".hold.reg_write"}, {15'd0, reg_write}, 16'd0);
        end
        mem_ack   = 1'b1;
        mem_rdata = pte;
        step();
        mem_ack   = 1'b0;
        mem_rdata = 16'($urandom);
        check({tag, ".resp.mem_req"}, {15'd0, mem_req}, 16'd0);
        check({tag, ".resp.mem_addr"}, mem_addr, 16'd0);
        check({tag, ".resp.busy"}, {15'd0, busy}, 16'd1);
        if (pte[1]) begin
            check({tag, ".reg_write"}, {15'd0, reg_write}, 16'd1);
            check({tag, ".done"}, {15'd0, done}, 16'd1);
            check({tag, ".reg_data"}, reg_data, pte | 16'd1);
            check({tag, ".pte_fault"}, {15'd0, pte_fault}, 16'd0);
        end else begin
            check({tag, ".inv.pte_fault"}, {15'd0, pte_fault}, 16'd1);
            check({tag, ".inv.reg_write"}, {15'd0, reg_write}, 16'd0);
            check({tag, ".inv.reg_data"}, reg_data, 16'd0);
            check({tag, ".inv.done"}, {15'd0, done}, 16'd0);
        end
        step();
        check_idle({tag, ".after"});
        // A stray acknowledge while idle must not produce a write.
        mem_ack   = 1'b1;
        mem_rdata = 16'hFFFF;
        step();
        mem_ack   = 1'b0;
        check_idle({tag, ".stray_ack"});
    endtask

    initial begin
        reset       = 1'b1;
        enable      = 1'b0;
        fault_valid = 1'b0;
        fault_info  = '0;
        ptbase      = '0;
        mem_ack     = 1'b0;
        mem_rdata   = '0;
        step();
        step();
        check_idle("reset");
        reset = 1'b0;
        step();
        check_idle("post_reset");

        run_fault("refill", 16'h4000, 16'hA006, 16'h7C06, 0, 1'b0, 1'b0);
        run_fault("invalid_pte", 16'h4000, 16'hA006, 16'h7C04, 0, 1'b0, 1'b0);
        run_fault("protection", 16'h4000, 16'hA004, 16'h0000, 0, 1'b0, 1'b0);
        run_fault("wrap", 16'hFFF0, 16'hE00E, 16'h1232, 1, 1'b0, 1'b0);
        run_fault("backpressure", 16'h4000, 16'hA006, 16'h7C06, 5, 1'b1, 1'b0);
        run_fault("enable_drop", 16'h2000, 16'h400A, 16'h0F0E, 2, 1'b0, 1'b1);

        // Fault while disabled is ignored.
        enable      = 1'b0;
        fault_valid = 1'b1;
        fault_info  = 16'hA006;
        ptbase      = 16'h4000;
        step();
        fault_valid = 1'b0;
        check_idle("disabled");

        // Reset while fetching aborts; a later acknowledge is ignored.
        enable      = 1'b1;
        fault_valid = 1'b1;
        fault_info  = 16'hA006;
        ptbase      = 16'h4000;
        step();
        fault_valid = 1'b0;
        check("abort.mem_req_before", {15'd0, mem_req}, 16'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("abort.mem_req", {15'd0, mem_req}, 16'd0);
        check("abort.busy", {15'd0, busy}, 16'd0);
        mem_ack   = 1'b1;
        mem_rdata = 16'h7C06;
        step();
        mem_ack = 1'b0;
        check_idle("abort.late_ack");

        for (int t = 0; t < 40; t++) begin
            logic [15:0] finfo;
            finfo = 16'($urandom) & 16'hFFFE;
            run_fault($sformatf("rand%0d", t), 16'($urandom), finfo, 16'($urandom),
                      int'($urandom_range(0, 4)), 1'($urandom), 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mmu_refill.md
MMU_REFILL -- requirements
Module: mmu_refill

Interface
REQ-001 SHALL have parameter RV, default 16, meaning data/address word width.
REQ-002 SHALL have parameter VA, default RV, meaning virtual address width.
REQ-003 SHALL have parameter NMMU, default 8, meaning the MMU entries per space; VPN width K = log2(NMMU).
REQ-004 SHALL have port clk  in  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port enable  in  1  refill engine enable.
REQ-007 SHALL have port fault_valid  in  1  one-cycle pulse: the MMU has latched a fault.
REQ-008 SHALL have port fault_info  in  RV  MMU fault register: [RV-1:RV-K] VPN, [3] ins, [2] sup, [1] type (1 = miss, 0 = write/protection), [0] 0.
REQ-009 SHALL have port ptbase  in  RV  page-table byte base address.
REQ-010 SHALL have port mem_req  out  1  memory read request.
REQ-011 SHALL have port mem_addr  out  RV  memory read byte address.
REQ-012 SHALL have port mem_ack  in  1  read data valid, one cycle.
REQ-013 SHALL have port mem_rdata  in  RV  page-table entry (PTE).
REQ-014 SHALL have port reg_write  out  1  MMU register write strobe.
REQ-015 SHALL have port reg_data  out  RV  MMU register write data.
REQ-016 SHALL have port busy  out  1  refill in progress.
REQ-017 SHALL have port done  out  1  one-cycle pulse: refill written.
REQ-018 SHALL have port pte_fault  out  1  one-cycle pulse: refill impossible; software trap required.

Function
REQ-019 SHALL implement the states IDLE, FETCH, WRITE and FAIL.
REQ-020 In IDLE, when fault_valid and enable are both 1, the block SHALL latch fault_info and ptbase; it SHALL go to FETCH if fault_info[1] = 1, else to FAIL.
REQ-021 In IDLE, fault_valid SHALL be ignored when enable = 0.
REQ-022 The table index SHALL be idx = {sup, ins, VPN}, which is K+2 bits wide.
REQ-023 mem_addr SHALL equal ptbase + (idx << 1), truncated modulo 2^RV, so that wrap-around is silent.
REQ-024 In FETCH, mem_req SHALL be 1 and mem_addr SHALL be stable until the cycle mem_ack is sampled 1.
REQ-025 When mem_ack is sampled 1, the block SHALL capture mem_rdata; it SHALL then go to WRITE if mem_rdata[1] = 1, else to FAIL.
REQ-026 In WRITE, for exactly one cycle, reg_write SHALL be 1, done SHALL be 1, and reg_data SHALL equal {pte[RV-1:1], 1'b1} (bit 0 forced to 1 = entry write); the block SHALL then return to IDLE.
REQ-027 In FAIL, for exactly one cycle, pte_fault SHALL be 1, with no reg_write and no mem_req; the block SHALL then return to IDLE.
REQ-028 Latency: fault_valid in cycle N SHALL produce mem_req in cycle N+1; mem_ack in cycle M SHALL produce reg_write/done in cycle M+1; a protection fault in cycle N SHALL produce pte_fault in cycle N+1.
REQ-029 busy SHALL be 1 in every non-IDLE state.
REQ-030 fault_valid SHALL be ignored while busy.
REQ-031 mem_ack SHALL be ignored outside FETCH.
REQ-032 Deasserting enable mid-refill SHALL NOT abort the refill.
REQ-033 reg_data SHALL be 0 whenever reg_write = 0.
REQ-034 mem_addr SHALL be 0 whenever mem_req = 0.

Reset
REQ-035 When reset = 1, the block SHALL enter IDLE, and mem_req, reg_write, reg_data, mem_addr, busy, done and pte_fault SHALL all be 0.
REQ-036 On the next edge, reset mid-operation SHALL abort the refill and drop mem_req; a later mem_ack SHALL be ignored.

Verification
REQ-037 A bench SHALL cover the refill case: ptbase=16'h4000, fault_info=16'hA006 (VPN 5, sup 1, ins 0, miss) -> idx 21, mem_req with mem_addr=16'h402A next cycle; mem_rdata=16'h7C06 with ack -> next cycle reg_write=1, reg_data=16'h7C07, done=1.
REQ-038 A bench SHALL cover the invalid-PTE case: same fault, mem_rdata=16'h7C04 -> pte_fault=1 for one cycle, reg_write stays 0, busy=0 afterwards.
REQ-039 A bench SHALL cover the protection-fault case: fault_info=16'hA004 -> pte_fault=1 one cycle after, mem_req never asserted.
REQ-040 A bench SHALL cover wrap-around: ptbase=16'hFFF0, fault_info=16'hE00E (idx 31) -> mem_addr=16'h002E.
REQ-041 A bench SHALL cover back-pressure and collision: mem_ack delayed 5 cycles, with a second fault_valid during FETCH -> mem_addr held constant, second fault ignored, exactly one reg_write.
REQ-042 A bench SHALL cover reset mid-operation: reset in FETCH -> next cycle mem_req=0, busy=0; a subsequent mem_ack -> no reg_write.
